// File: rtl/decrypted_word_packer.sv
// decrypted_word_packer
//   Packs the character stream of a decryption engine into OUT_WIDTH-bit
//   words (first character in the MSB lane). Completed words go through a
//   small show-ahead FIFO to a valid/ready word bus. The final word of each
//   message carries last_o, and byte_en_o marks which lanes hold characters.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   data_i/valid_i          character and strobe from the engine
//   busy_i                  engine busy; a falling edge ends the message
//   data_o/byte_en_o/last_o FIFO head word, lane mask, end-of-message flag
//   valid_o/ready_i         output handshake (pop on valid_o & ready_i)
//   overflow_o              sticky: a word was dropped on a full FIFO
//   busy_o                  characters held or words buffered
module decrypted_word_packer #(
  parameter int unsigned D_WIDTH    = 8,
  parameter int unsigned OUT_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [D_WIDTH-1:0]             data_i,
  input  logic                           valid_i,
  input  logic                           busy_i,
  output logic [OUT_WIDTH-1:0]           data_o,
  output logic [OUT_WIDTH/D_WIDTH-1:0]   byte_en_o,
  output logic                           last_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic                           overflow_o,
  output logic                           busy_o
);

  localparam int unsigned LANES = OUT_WIDTH / D_WIDTH;
  localparam int unsigned CNT_W = $clog2(LANES + 1);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LANES);

  // Top n lanes set (MSB lane is filled first).
  function automatic logic [LANES-1:0] lane_mask(input logic [CNT_W-1:0] n);
    lane_mask = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (CNT_W'(i) < n) lane_mask[LANES-1-i] = 1'b1;
    end
  endfunction

  // Packer state
  logic [OUT_WIDTH-1:0] r_pack;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_pend;
  logic                 r_busy_q;

  // FIFO state
  logic [OUT_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [LANES-1:0]     r_mem_be   [FIFO_DEPTH];
  logic                 r_mem_last [FIFO_DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic                 r_overflow;

  logic                 w_end;
  logic [OUT_WIDTH-1:0] w_lane;
  logic [OUT_WIDTH-1:0] w_pack_n;
  logic [CNT_W-1:0]     w_cnt_n;
  logic                 w_pend_n;
  logic                 w_push;
  logic [OUT_WIDTH-1:0] w_push_data;
  logic [LANES-1:0]     w_push_be;
  logic                 w_push_last;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_wr_en;

  always_comb begin
    w_end       = r_busy_q & ~busy_i;
    w_pack_n    = r_pack;
    w_cnt_n     = r_cnt;
    w_pend_n    = 1'b0;
    w_push      = 1'b0;
    w_push_data = r_pack;
    w_push_be   = lane_mask(r_cnt);
    w_push_last = 1'b0;

    // Pack register with the incoming character in lane r_cnt; a fresh word
    // starts from zero so unfilled lanes read 0.
    w_lane = (r_cnt == '0) ? '0 : r_pack;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (CNT_W'(i) == r_cnt) w_lane[OUT_WIDTH-1-i*D_WIDTH -: D_WIDTH] = data_i;
    end

    if (r_pend) begin
      // Second half of a full-word collision: flush the single-character word.
      // Any valid_i in this cycle is a protocol violation and is dropped.
      w_push      = 1'b1;
      w_push_last = 1'b1;
      w_cnt_n     = '0;
    end else if (valid_i) begin
      if (r_cnt == CNT_FULL) begin
        w_push      = 1'b1;
        w_push_be   = '1;
        w_pack_n    = '0;
        w_pack_n[OUT_WIDTH-1 -: D_WIDTH] = data_i;
        w_cnt_n     = CNT_W'(1);
        w_pend_n    = w_end;
      end else begin
        w_pack_n = w_lane;
        w_cnt_n  = r_cnt + CNT_W'(1);
        if (w_end) begin
          w_push      = 1'b1;
          w_push_data = w_lane;
          w_push_be   = lane_mask(r_cnt + CNT_W'(1));
          w_push_last = 1'b1;
          w_cnt_n     = '0;
        end
      end
    end else if (w_end && (r_cnt != '0)) begin
      w_push      = 1'b1;
      w_push_last = 1'b1;
      w_cnt_n     = '0;
    end
  end

  always_comb begin
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
              (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_pop   = ~w_empty & ready_i;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    w_wr_en = w_push & (~w_full | w_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pack     <= '0;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_busy_q   <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pack   <= w_pack_n;
      r_cnt    <= w_cnt_n;
      r_pend   <= w_pend_n;
      r_busy_q <= busy_i;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_data[r_wr_ptr[AW-1:0]] <= w_push_data;
      r_mem_be[r_wr_ptr[AW-1:0]]   <= w_push_be;
      r_mem_last[r_wr_ptr[AW-1:0]] <= w_push_last;
    end
  end

  always_comb begin
    valid_o    = ~w_empty;
    data_o     = w_empty ? '0 : r_mem_data[r_rd_ptr[AW-1:0]];
    byte_en_o  = w_empty ? '0 : r_mem_be[r_rd_ptr[AW-1:0]];
    last_o     = w_empty ? 1'b0 : r_mem_last[r_rd_ptr[AW-1:0]];
    overflow_o = r_overflow;
    busy_o     = (r_cnt != '0) | r_pend | ~w_empty;
  end

endmodule

// File: tb/tb_decrypted_word_packer.sv
// Directed bench for decrypted_word_packer (8-bit characters, 32-bit words,
// 4-entry FIFO). Words accepted on the output bus are logged at the falling
// edge and compared against hand-computed expectations in each test task.
module tb_decrypted_word_packer;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic [7:0]  data_i  = '0;
  logic        valid_i = 1'b0;
  logic        busy_i  = 1'b0;
  logic        ready_i = 1'b0;
  logic [31:0] data_o;
  logic [3:0]  byte_en_o;
  logic        last_o;
  logic        valid_o;
  logic        overflow_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  be;
    logic        l;
  } word_t;

  word_t popq[$];
  int    popcyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  decrypted_word_packer #(.D_WIDTH(8), .OUT_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
    .busy_i(busy_i), .data_o(data_o), .byte_en_o(byte_en_o),
    .last_o(last_o), .valid_o(valid_o), .ready_i(ready_i),
    .overflow_o(overflow_o), .busy_o(busy_o)
  );

  always @(negedge clk) begin
    if (rst_n && valid_o && ready_i) begin
      popq.push_back(word_t'({data_o, byte_en_o, last_o}));
      popcyc.push_back(cyc);
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic b,
                       input logic r);
    @(posedge clk);
    #1;
    valid_i = v;
    data_i  = d;
    busy_i  = b;
    ready_i = r;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_o && n < budget);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: busy_o=%b after %0d cycles, expected 0", name, busy_o, budget);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({data_o, byte_en_o, last_o, valid_o, overflow_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: data=%h be=%b last=%b valid=%b ovf=%b busy=%b, expected all 0",
               data_o, byte_en_o, last_o, valid_o, overflow_o, busy_o);
    end
    #10 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({valid_o, overflow_o, busy_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: valid=%b ovf=%b busy=%b, expected 000", valid_o, overflow_o, busy_o);
    end
  endtask

  task automatic test_two_words();
    word_t exp [2];
    exp[0] = '{32'h41424344, 4'b1111, 1'b0};
    exp[1] = '{32'h45464748, 4'b1111, 1'b1};
    popq.delete();
    for (int k = 0; k < 8; k++) drive(1'b1, 8'(8'h41 + k), 1'b1, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    wait_idle(20, "two_words");
    checks++;
    if (popq.size() != 2) begin
      errors++;
      $display("FAIL two_words count: got %0d words, expected 2", popq.size());
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= popq.size()) begin
        errors++;
        $display("FAIL two_words word%0d: missing, expected %h/%b/%b", i, exp[i].d, exp[i].be, exp[i].l);
      end else if (popq[i] !== exp[i]) begin
        errors++;
        $display("FAIL two_words word%0d: got %h/%b/%b expected %h/%b/%b", i,
                 popq[i].d, popq[i].be, popq[i].l, exp[i].d, exp[i].be, exp[i].l);
      end
    end
  endtask

  task automatic test_partial();
    word_t exp [2];
    exp[0] = '{32'h41424344, 4'b1111, 1'b0};
    exp[1] = '{32'h45460000, 4'b1100, 1'b1};
    popq.delete();
    for (int k = 0; k < 6; k++) drive(1'b1, 8'(8'h41 + k), 1'b1, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    wait_idle(20, "partial");
    checks++;
    if (popq.size() != 2) begin
      errors++;
      $display("FAIL partial count: got %0d words, expected 2", popq.size());
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= popq.size()) begin
        errors++;
        $display("FAIL partial word%0d: missing, expected %h/%b/%b", i, exp[i].d, exp[i].be, exp[i].l);
      end else if (popq[i] !== exp[i]) begin
        errors++;
        $display("FAIL partial word%0d: got %h/%b/%b expected %h/%b/%b", i,
                 popq[i].d, popq[i].be, popq[i].l, exp[i].d, exp[i].be, exp[i].l);
      end
    end
  endtask

  task automatic test_collision();
    word_t exp [2];
    exp[0] = '{32'h41424344, 4'b1111, 1'b0};
    exp[1] = '{32'h45000000, 4'b1000, 1'b1};
    popq.delete();
    popcyc.delete();
    for (int k = 0; k < 4; k++) drive(1'b1, 8'(8'h41 + k), 1'b1, 1'b1);
    drive(1'b1, 8'h45, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    wait_idle(20, "collision");
    checks++;
    if (popq.size() != 2) begin
      errors++;
      $display("FAIL collision count: got %0d words, expected 2", popq.size());
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= popq.size()) begin
        errors++;
        $display("FAIL collision word%0d: missing, expected %h/%b/%b", i, exp[i].d, exp[i].be, exp[i].l);
      end else if (popq[i] !== exp[i]) begin
        errors++;
        $display("FAIL collision word%0d: got %h/%b/%b expected %h/%b/%b", i,
                 popq[i].d, popq[i].be, popq[i].l, exp[i].d, exp[i].be, exp[i].l);
      end
    end
    checks++;
    if (popcyc.size() < 2 || (popcyc[1] - popcyc[0]) != 1) begin
      errors++;
      $display("FAIL collision spacing: second word not exactly one cycle after first (%0d entries)",
               popcyc.size());
    end
  endtask

  task automatic test_empty_message();
    popq.delete();
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) drive(1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (popq.size() != 0 || valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL empty_msg: words=%0d valid=%b busy=%b, expected 0/0/0", popq.size(), valid_o, busy_o);
    end
  endtask

  task automatic test_backpressure();
    word_t exp [4];
    exp[0] = '{32'h41424344, 4'b1111, 1'b0};
    exp[1] = '{32'h45464748, 4'b1111, 1'b0};
    exp[2] = '{32'h494a4b4c, 4'b1111, 1'b0};
    exp[3] = '{32'h4d4e4f50, 4'b1111, 1'b1};
    popq.delete();
    for (int k = 0; k < 16; k++) drive(1'b1, 8'(8'h41 + k), 1'b1, 1'((k % 2)));
    for (int k = 16; k < 24; k++) drive(1'b0, 8'h00, 1'b0, 1'((k % 2)));
    wait_idle(20, "backpressure");
    checks++;
    if (popq.size() != 4) begin
      errors++;
      $display("FAIL backpressure count: got %0d words, expected 4", popq.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= popq.size()) begin
        errors++;
        $display("FAIL backpressure word%0d: missing, expected %h/%b/%b", i, exp[i].d, exp[i].be, exp[i].l);
      end else if (popq[i] !== exp[i]) begin
        errors++;
        $display("FAIL backpressure word%0d: got %h/%b/%b expected %h/%b/%b", i,
                 popq[i].d, popq[i].be, popq[i].l, exp[i].d, exp[i].be, exp[i].l);
      end
    end
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL backpressure overflow: got %b expected 0", overflow_o);
    end
  endtask

  task automatic test_overflow();
    word_t exp [4];
    exp[0] = '{32'h41424344, 4'b1111, 1'b0};
    exp[1] = '{32'h45464748, 4'b1111, 1'b0};
    exp[2] = '{32'h494a4b4c, 4'b1111, 1'b0};
    exp[3] = '{32'h4d4e4f50, 4'b1111, 1'b0};
    popq.delete();
    for (int k = 0; k < 20; k++) drive(1'b1, 8'(8'h41 + k), 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow flag: got %b expected 1", overflow_o);
    end
    checks++;
    if (valid_o !== 1'b1 || data_o !== 32'h41424344 || last_o !== 1'b0) begin
      errors++;
      $display("FAIL overflow head: valid=%b data=%h last=%b expected 1/41424344/0", valid_o, data_o, last_o);
    end
    for (int k = 0; k < 8; k++) drive(1'b0, 8'h00, 1'b0, 1'b1);
    wait_idle(20, "overflow");
    checks++;
    if (popq.size() != 4) begin
      errors++;
      $display("FAIL overflow count: got %0d words, expected 4", popq.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= popq.size()) begin
        errors++;
        $display("FAIL overflow word%0d: missing, expected %h/%b/%b", i, exp[i].d, exp[i].be, exp[i].l);
      end else if (popq[i] !== exp[i]) begin
        errors++;
        $display("FAIL overflow word%0d: got %h/%b/%b expected %h/%b/%b", i,
                 popq[i].d, popq[i].be, popq[i].l, exp[i].d, exp[i].be, exp[i].l);
      end
    end
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow sticky: got %b expected 1", overflow_o);
    end
  endtask

  task automatic test_reset_mid_message();
    word_t exp;
    exp = '{32'h61626364, 4'b1111, 1'b1};
    popq.delete();
    // One word buffered, one character held, overflow still set from before.
    for (int k = 0; k < 5; k++) drive(1'b1, 8'(8'h41 + k), 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    #3;
    checks++;
    if (valid_o !== 1'b1 || busy_o !== 1'b1 || data_o !== 32'h41424344) begin
      errors++;
      $display("FAIL pre_reset: valid=%b busy=%b data=%h expected 1/1/41424344", valid_o, busy_o, data_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({data_o, byte_en_o, last_o, valid_o, overflow_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL mid_reset: data=%h be=%b last=%b valid=%b ovf=%b busy=%b, expected all 0",
               data_o, byte_en_o, last_o, valid_o, overflow_o, busy_o);
    end
    valid_i = 1'b0;
    busy_i  = 1'b0;
    #3 rst_n = 1'b1;
    popq.delete();
    for (int k = 0; k < 4; k++) drive(1'b1, 8'(8'h61 + k), 1'b1, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    wait_idle(20, "reset_mid");
    checks++;
    if (popq.size() != 1) begin
      errors++;
      $display("FAIL reset_mid count: got %0d words, expected 1", popq.size());
    end
    checks++;
    if (popq.size() < 1) begin
      errors++;
      $display("FAIL reset_mid word: missing, expected %h/%b/%b", exp.d, exp.be, exp.l);
    end else if (popq[0] !== exp) begin
      errors++;
      $display("FAIL reset_mid word: got %h/%b/%b expected %h/%b/%b",
               popq[0].d, popq[0].be, popq[0].l, exp.d, exp.be, exp.l);
    end
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid overflow: got %b expected 0", overflow_o);
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_partial();
    test_collision();
    test_empty_message();
    test_backpressure();
    test_overflow();
    test_reset_mid_message();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog timeout");
  end

endmodule
